fetch_pc_ctrl: RTL and testbench

- Fetch and next-PC stage directly upstream of the opcode decoder.
- Owns the PC, fetches instructions over a ready/request handshake, and presents instr[15:12] to the decoder.
- Consumes the decoder's branch/call/ret/halt/set_zero/set_over strobes plus ALU status. Holds the Z/V/N flag register, resolves conditional branches and computes the next PC.

---
 rtl/wisc_pkg.sv | 45 ++++
 rtl/branch_cond.sv | 37 +++
 rtl/fetch_pc_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared ISA constants, FSM state type and flag layout
// Purpose: opcode and branch-condition encodings, fetch FSM states and
//          flag bit positions shared by the fetch/next-PC stage.
// Ports:   none (package).
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_RED    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_CALL   = 4'hD;
  localparam logic [3:0] OP_RET    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CC_NEQ  = 3'b000;
  localparam logic [2:0] CC_EQ   = 3'b001;
  localparam logic [2:0] CC_GT   = 3'b010;
  localparam logic [2:0] CC_LT   = 3'b011;
  localparam logic [2:0] CC_GTE  = 3'b100;
  localparam logic [2:0] CC_LTE  = 3'b101;
  localparam logic [2:0] CC_OVFL = 3'b110;
  localparam logic [2:0] CC_UNC  = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Flag register layout is {Z,V,N}.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - conditional branch resolution from ccc and flags
// Purpose: decides whether a B instruction is taken.
// Ports:   i_ccc   [2:0] condition code (instr[11:9])
//          i_flags [2:0] current {Z,V,N}
//          o_taken       branch condition satisfied
module branch_cond
  import wisc_pkg::*;
(
  input  logic [2:0] i_ccc,
  input  logic [2:0] i_flags,
  output logic       o_taken
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = i_flags[FLAG_Z];
  assign w_v = i_flags[FLAG_V];
  assign w_n = i_flags[FLAG_N];

  always_comb begin
    o_taken = 1'b0;
    case (i_ccc)
      CC_NEQ:  o_taken = ~w_z;
      CC_EQ:   o_taken = w_z;
      CC_GT:   o_taken = ~w_z & ~w_n;
      CC_LT:   o_taken = w_n;
      CC_GTE:  o_taken = w_z | ~w_n;
      CC_LTE:  o_taken = w_n | w_z;
      CC_OVFL: o_taken = w_v;
      CC_UNC:  o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch FSM, PC, flag register and next-PC selection
// Purpose: owns the PC, fetches one instruction per >=3 cycles over a
//          req/rdy handshake, presents the opcode to the decoder and
//          retires each instruction by updating PC and {Z,V,N}.
// Ports:   clk, rst_n                       clock, async active-low reset
//          imem_req/imem_addr/imem_rdy/imem_data  instruction fetch handshake
//          instr, opcode, instr_valid        latched instruction to decoder
//          stall                             holds EXEC
//          branch/call/ret/halt/set_zero/set_over  decoder strobes
//          alu_zero/alu_ovfl/alu_neg         ALU status for flag update
//          ret_addr                          RET target (R15)
//          pc, link_pc, flags, halted        architectural state out
module fetch_pc_ctrl
  import wisc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic [15:0]       imem_data,
  output logic [15:0]       instr,
  output logic [3:0]        opcode,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              branch,
  input  logic              call,
  input  logic              ret,
  input  logic              halt,
  input  logic              set_zero,
  input  logic              set_over,
  input  logic              alu_zero,
  input  logic              alu_ovfl,
  input  logic              alu_neg,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_pc,
  output logic [2:0]        flags,
  output logic              halted
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic [2:0]        r_flags;
  logic              r_valid;
  logic              r_halted;

  logic              w_taken;
  logic [ADDR_W-1:0] w_link_pc;
  logic [ADDR_W-1:0] w_off_call;
  logic [ADDR_W-1:0] w_off_br;
  logic [ADDR_W-1:0] w_next_pc;

  branch_cond u_branch_cond (
    .i_ccc   (r_instr[11:9]),
    .i_flags (r_flags),
    .o_taken (w_taken)
  );

  // Offsets are sign-extended to the PC width so the adds wrap naturally.
  assign w_link_pc  = r_pc + ADDR_W'(1);
  assign w_off_call = {{(ADDR_W-12){r_instr[11]}}, r_instr[11:0]};
  assign w_off_br   = {{(ADDR_W-9){r_instr[8]}}, r_instr[8:0]};

  always_comb begin
    w_next_pc = w_link_pc;
    if (halt) begin
      w_next_pc = r_pc;
    end else if (ret) begin
      w_next_pc = ret_addr;
    end else if (call) begin
      w_next_pc = w_link_pc + w_off_call;
    end else if (branch && w_taken) begin
      w_next_pc = w_link_pc + w_off_br;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_instr  <= 16'h0000;
      r_flags  <= 3'b000;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rdy) begin
            r_instr <= imem_data;
            r_valid <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Strobes only matter on the retiring edge of EXEC.
          if (!stall) begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
            if (set_zero) begin
              r_flags[FLAG_Z] <= alu_zero;
            end
            if (set_over) begin
              r_flags[FLAG_V] <= alu_ovfl;
              r_flags[FLAG_N] <= alu_neg;
            end
            if (halt) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALTED;
            end else begin
              r_state  <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  // Reset leaves the FSM in FETCH, so the request is also gated by rst_n
  // to keep it low for as long as reset is held.
  assign imem_req    = rst_n & ((r_state == ST_FETCH) | (r_state == ST_WAIT));
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[15:12];
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign link_pc     = w_link_pc;
  assign flags       = r_flags;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        branch = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0;
  logic        set_zero = 1'b0, set_over = 1'b0;
  logic        alu_zero = 1'b0, alu_ovfl = 1'b0, alu_neg = 1'b0;
  logic [15:0] ret_addr = 16'h0000;
  logic [15:0] pc;
  logic [15:0] link_pc;
  logic [2:0]  flags;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  // Reference architectural state
  logic [15:0] m_pc;
  logic        mz, mv, mn;

  // Observations captured by the driver
  logic [15:0] d_addr, d_link, d_instr;
  logic [3:0]  d_opcode;
  logic        d_req_ok, d_addr_stable, d_valid_early, d_valid, d_stall_ok;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .stall(stall),
    .branch(branch), .call(call), .ret(ret), .halt(halt),
    .set_zero(set_zero), .set_over(set_over),
    .alu_zero(alu_zero), .alu_ovfl(alu_ovfl), .alu_neg(alu_neg),
    .ret_addr(ret_addr), .pc(pc), .link_pc(link_pc), .flags(flags), .halted(halted)
  );

  function automatic void model_reset();
    m_pc = 16'h0000; mz = 1'b0; mv = 1'b0; mn = 1'b0;
  endfunction

  // Architectural effect of retiring one instruction.
  function automatic void model_exec(input logic [15:0] ins, input logic br, cl, rt, hl,
                                     sz, so, az, ao, an, input logic [15:0] ra);
    bit take;
    int off12, off9, base;
    case (ins[11:9])
      3'd0: take = !mz;
      3'd1: take = mz;
      3'd2: take = !mz && !mn;
      3'd3: take = mn;
      3'd4: take = mz || !mn;
      3'd5: take = mn || mz;
      3'd6: take = mv;
      default: take = 1'b1;
    endcase
    off12 = ins[11] ? int'(ins[11:0]) - 4096 : int'(ins[11:0]);
    off9  = ins[8]  ? int'(ins[8:0]) - 512   : int'(ins[8:0]);
    base  = int'(m_pc) + 1;
    if (hl)              m_pc = m_pc;
    else if (rt)         m_pc = ra;
    else if (cl)         m_pc = 16'(base + off12);
    else if (br && take) m_pc = 16'(base + off9);
    else                 m_pc = 16'(base);
    if (sz) mz = az;
    if (so) begin mv = ao; mn = an; end
  endfunction

  task automatic garbage();
    branch = 1'($urandom); call = 1'($urandom); ret = 1'($urandom); halt = 1'($urandom);
    set_zero = 1'($urandom); set_over = 1'($urandom); stall = 1'($urandom);
    alu_zero = 1'($urandom); alu_ovfl = 1'($urandom); alu_neg = 1'($urandom);
    ret_addr = 16'($urandom);
  endtask

  task automatic quiet();
    branch = 0; call = 0; ret = 0; halt = 0; set_zero = 0; set_over = 0; stall = 0;
    alu_zero = 0; alu_ovfl = 0; alu_neg = 0;
  endtask

  // Starts at a negedge with the DUT in FETCH; ends at a negedge after the EXEC exit edge.
  task automatic exec_instr(input logic [15:0] data, input logic br, cl, rt, hl, sz, so,
                            az, ao, an, input logic [15:0] ra, input int nwait, input int nstall);
    logic [15:0] pc0;
    logic [2:0]  fl0;
    #1;
    d_addr = imem_addr; d_req_ok = imem_req; d_valid_early = instr_valid;
    d_addr_stable = 1'b1; d_stall_ok = 1'b1;
    garbage();
    @(posedge clk);
    for (int i = 0; i < nwait; i++) begin
      @(negedge clk);
      d_req_ok &= imem_req; d_valid_early |= instr_valid;
      if (imem_addr !== d_addr) d_addr_stable = 1'b0;
      garbage(); imem_rdy = 1'b0; imem_data = 16'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    d_req_ok &= imem_req; d_valid_early |= instr_valid;
    if (imem_addr !== d_addr) d_addr_stable = 1'b0;
    garbage(); imem_rdy = 1'b1; imem_data = data;
    @(posedge clk);
    @(negedge clk);
    imem_rdy = 1'b0; imem_data = 16'($urandom);
    d_valid = instr_valid; d_opcode = opcode; d_instr = instr; d_link = link_pc;
    pc0 = pc; fl0 = flags;
    for (int i = 0; i < nstall; i++) begin
      garbage(); stall = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (pc !== pc0 || flags !== fl0 || instr_valid !== 1'b1) d_stall_ok = 1'b0;
    end
    stall = 1'b0; branch = br; call = cl; ret = rt; halt = hl;
    set_zero = sz; set_over = so; alu_zero = az; alu_ovfl = ao; alu_neg = an; ret_addr = ra;
    @(posedge clk);
    model_exec(data, br, cl, rt, hl, sz, so, az, ao, an, ra);
    @(negedge clk);
    quiet();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    vectors++; if (instr !== 16'h0000 || flags !== 3'b000) begin miscompares++; $display("FAIL reset_instr_flags: got %h/%b expected 0000/000", instr, flags); end
    vectors++; if (instr_valid !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL reset_valid_halted: got %b/%b expected 0/0", instr_valid, halted); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_fetch();
    exec_instr(16'h0123, 0, 0, 0, 0, 1, 0, 1, 0, 0, 16'h0, 0, 0);
    vectors++; if (d_addr !== 16'h0000 || d_req_ok !== 1'b1) begin miscompares++; $display("FAIL basic_addr_req: got %h/%b expected 0000/1", d_addr, d_req_ok); end
    vectors++; if (d_valid !== 1'b1 || d_valid_early !== 1'b0) begin miscompares++; $display("FAIL basic_valid_timing: got %b/%b expected 1/0", d_valid, d_valid_early); end
    vectors++; if (d_opcode !== 4'h0 || d_instr !== 16'h0123) begin miscompares++; $display("FAIL basic_opcode: got %h/%h expected 0/0123", d_opcode, d_instr); end
    vectors++; if (pc !== 16'h0001) begin miscompares++; $display("FAIL basic_pc: got %h expected 0001", pc); end
    vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL basic_flags: got %b expected 100", flags); end
  endtask

  task automatic test_branch();
    exec_instr(16'hE000, 0, 0, 1, 0, 1, 0, 1, 0, 0, 16'h0005, 0, 0);
    exec_instr(16'hC3FE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0);
    vectors++; if (pc !== 16'h0004) begin miscompares++; $display("FAIL branch_taken_back: got %h expected 0004", pc); end
    exec_instr(16'hE000, 0, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0005, 0, 0);
    exec_instr(16'hC3FE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    vectors++; if (pc !== 16'h0006) begin miscompares++; $display("FAIL branch_not_taken: got %h expected 0006", pc); end
  endtask

  task automatic test_call_ret();
    exec_instr(16'hE000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0020, 0, 0);
    exec_instr(16'hD010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0);
    vectors++; if (d_link !== 16'h0021) begin miscompares++; $display("FAIL call_link_pc: got %h expected 0021", d_link); end
    vectors++; if (pc !== 16'h0031) begin miscompares++; $display("FAIL call_target: got %h expected 0031", pc); end
    exec_instr(16'hE000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0021, 0, 0);
    vectors++; if (pc !== 16'h0021) begin miscompares++; $display("FAIL ret_target: got %h expected 0021", pc); end
  endtask

  task automatic test_wrap();
    exec_instr(16'hE000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 0, 0);
    exec_instr(16'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL wrap_seq: got %h expected 0000", pc); end
    exec_instr(16'hE000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFE, 0, 0);
    exec_instr(16'hCE05, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    vectors++; if (pc !== 16'h0004) begin miscompares++; $display("FAIL wrap_branch: got %h expected 0004", pc); end
  endtask

  task automatic test_stall_handshake();
    logic [15:0] exp_pc;
    exp_pc = m_pc;
    exec_instr(16'h2345, 0, 0, 0, 0, 1, 1, 0, 1, 1, 16'h0, 10, 3);
    vectors++; if (d_req_ok !== 1'b1 || d_addr_stable !== 1'b1 || d_addr !== exp_pc) begin miscompares++; $display("FAIL wait_handshake: got req %b stable %b addr %h expected 1 1 %h", d_req_ok, d_addr_stable, d_addr, exp_pc); end
    vectors++; if (d_stall_ok !== 1'b1) begin miscompares++; $display("FAIL stall_hold: got %b expected 1", d_stall_ok); end
    vectors++; if (pc !== m_pc || flags !== {mz, mv, mn}) begin miscompares++; $display("FAIL stall_exit: got %h/%b expected %h/%b", pc, flags, m_pc, {mz, mv, mn}); end
  endtask

  task automatic test_random();
    logic [15:0] data, ra, pc_before;
    logic br, cl, rt;
    for (int n = 0; n < 40; n++) begin
      data = 16'($urandom); ra = 16'($urandom);
      br = 1'($urandom); cl = ($urandom_range(0, 4) == 0); rt = ($urandom_range(0, 4) == 0);
      pc_before = m_pc;
      exec_instr(data, br, cl, rt, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), ra, $urandom_range(0, 2), $urandom_range(0, 2));
      vectors++; if (d_addr !== pc_before || d_link !== 16'(pc_before + 16'd1)) begin miscompares++; $display("FAIL rand_addr_link[%0d]: got %h/%h expected %h/%h", n, d_addr, d_link, pc_before, 16'(pc_before + 16'd1)); end
      vectors++; if (d_opcode !== data[15:12]) begin miscompares++; $display("FAIL rand_opcode[%0d]: got %h expected %h", n, d_opcode, data[15:12]); end
      vectors++; if (pc !== m_pc) begin miscompares++; $display("FAIL rand_pc[%0d]: got %h expected %h (instr %h)", n, pc, m_pc, data); end
      vectors++; if (flags !== {mz, mv, mn}) begin miscompares++; $display("FAIL rand_flags[%0d]: got %b expected %b", n, flags, {mz, mv, mn}); end
    end
  endtask

  task automatic test_mid_reset();
    exec_instr(16'hE000, 0, 0, 1, 0, 1, 1, 1, 1, 1, 16'h1234, 0, 0);
    // Reset while waiting on imem
    #1; garbage(); stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b0 || pc !== 16'h0000 || flags !== 3'b000) begin miscompares++; $display("FAIL reset_mid_wait: got req %b pc %h flags %b expected 0 0000 000", imem_req, pc, flags); end
    @(negedge clk);
    rst_n = 1'b1; model_reset(); quiet();
    // Reset while executing a RET
    #1;
    @(posedge clk);
    @(negedge clk); imem_rdy = 1'b1; imem_data = 16'hE000;
    @(posedge clk);
    @(negedge clk); imem_rdy = 1'b0; ret = 1'b1; ret_addr = 16'h5555;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 16'h0000) begin miscompares++; $display("FAIL reset_mid_exec: got valid %b req %b pc %h expected 0 0 0000", instr_valid, imem_req, pc); end
    @(negedge clk);
    rst_n = 1'b1; model_reset(); quiet();
    exec_instr(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    vectors++; if (d_addr !== 16'h0000 || pc !== 16'h0001) begin miscompares++; $display("FAIL reset_restart: got addr %h pc %h expected 0000 0001", d_addr, pc); end
  endtask

  task automatic test_halt();
    logic [15:0] pc_h;
    logic        req_seen, valid_seen, frozen_bad;
    exec_instr(16'hE000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0300, 0, 0);
    exec_instr(16'hF000, 0, 0, 0, 1, 1, 1, 1, 1, 0, 16'h0, 0, 1);
    vectors++; if (halted !== 1'b1 || pc !== 16'h0300) begin miscompares++; $display("FAIL halt_enter: got halted %b pc %h expected 1 0300", halted, pc); end
    pc_h = pc; req_seen = 0; valid_seen = 0; frozen_bad = 0;
    for (int i = 0; i < 20; i++) begin
      garbage(); imem_rdy = 1'($urandom); imem_data = 16'($urandom);
      @(negedge clk);
      req_seen |= imem_req; valid_seen |= instr_valid;
      if (pc !== pc_h || instr !== 16'hF000 || flags !== {mz, mv, mn} || halted !== 1'b1) frozen_bad = 1;
    end
    vectors++; if (req_seen !== 1'b0 || valid_seen !== 1'b0) begin miscompares++; $display("FAIL halt_quiet: got req %b valid %b expected 0 0", req_seen, valid_seen); end
    vectors++; if (frozen_bad !== 1'b0) begin miscompares++; $display("FAIL halt_frozen: got %b expected 0", frozen_bad); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (pc !== 16'h0000 || halted !== 1'b0) begin miscompares++; $display("FAIL halt_reset: got pc %h halted %b expected 0000 0", pc, halted); end
    quiet(); imem_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; model_reset();
  endtask

  initial begin
    quiet();
    test_reset();
    test_basic_fetch();
    test_branch();
    test_call_ret();
    test_wrap();
    test_stall_handshake();
    test_random();
    test_mid_reset();
    test_halt();
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
